uart_rx_byte: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_byte.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int DATA_BITS = 8;

   function automatic int tick_div(
      input int clk_freq,
      input int baud,
      input int os
   );
      return clk_freq / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: free-running counter with a synchronous clear
// so the tick phase can be realigned to an incoming edge.
module uart_baud_tick #(
   parameter int DIV = 651
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 oversampling UART receiver; define UART_RX_PARITY_EN for an
// extra even-parity bit between the data bits and the stop bit.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST_S  = SW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_B  = 3'(DATA_BITS - 1);

   state_t               r_state;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic                 r_rx_d;
   logic [SW-1:0]        r_samp;
   logic [2:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [7:0]           r_data_out;
   logic                 r_data_ready;
   logic                 r_frame_err;
   logic                 r_busy;

   logic w_fall;
   logic w_clr;
   logic w_tick;
   logic w_par_ok;
   logic w_last;

   // Two-flop synchroniser plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_d    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_rx_d    <= r_rx_s;
      end
   end

   assign w_fall = r_rx_d & ~r_rx_s;
   assign w_clr  = (r_state == IDLE) & w_fall;
   assign w_last = w_tick & (r_samp == LAST_S);

   uart_baud_tick #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic r_parity_err;

   assign w_par_ok   = ~(^{r_shift, r_par_bit});
   assign parity_err = r_parity_err;
`else
   assign w_par_ok   = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_samp       <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_data_out   <= 8'h00;
         r_data_ready <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_data_ready <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state <= START;
                  r_samp  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (w_tick) begin
                  if (r_samp == HALF_M1) begin
                     r_samp <= '0;
                     if (!r_rx_s) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                     end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_samp <= r_samp + 1'b1;
                  end
               end
            end
            DATA: begin
               if (w_last) begin
                  r_samp    <= '0;
                  r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_B) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end else if (w_tick) begin
                  r_samp <= r_samp + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_last) begin
                  r_samp    <= '0;
                  r_par_bit <= r_rx_s;
                  r_state   <= STOP;
               end else if (w_tick) begin
                  r_samp <= r_samp + 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_last) begin
                  r_samp  <= '0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  if (r_rx_s && w_par_ok) begin
                     r_data_out   <= r_shift;
                     r_data_ready <= 1'b1;
                  end
                  r_frame_err <= ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                  r_parity_err <= ~w_par_ok;
`endif
               end else if (w_tick) begin
                  r_samp <= r_samp + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = r_data_out;
   assign data_ready = r_data_ready;
   assign frame_err  = r_frame_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: 160 clk per bit, TICK_DIV = 10.
module tb_uart_rx_byte;

   localparam int BIT_CLK = 160;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] data_out;
   logic       data_ready;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   uart_rx_byte #(
      .CLK_FREQ   (1_600_000),
      .BAUD       (10_000),
      .OVERSAMPLE (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .data_out   (data_out),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   typedef struct {
      logic       dr;
      logic       fe;
      logic       pe;
      logic [7:0] d;
      int         t0;
      int         lat;
   } exp_t;

   exp_t       q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [7:0] exp_dout = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every output pulse pops one expected event
   always @(negedge clk) begin
      if (rst_n && (data_ready || frame_err || parity_err)) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected pulse: dr=%0b fe=%0b pe=%0b expected none",
                     data_ready, frame_err, parity_err);
         end else begin
            exp_t e;
            int   lat;
            e = q.pop_front();
            lat = cyc - e.t0;
            chk("flags {dr,fe,pe}", {29'd0, data_ready, frame_err, parity_err},
                {29'd0, e.dr, e.fe, e.pe});
            chk("data_out at pulse", {24'd0, data_out}, {24'd0, e.d});
            n_vec++;
            if (lat < e.lat - 12 || lat > e.lat + 12) begin
               n_err++;
               $display("FAIL latency: got %0d expected %0d+-12", lat, e.lat);
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input logic has_par, input logic par);
      exp_t e;
      logic ok;
      logic perr;
      perr = has_par & (^{b, par});
      ok   = stop & ~perr;
      e.dr  = ok;
      e.fe  = ~stop;
      e.pe  = perr;
      if (ok) exp_dout = b;
      e.d   = exp_dout;
      e.t0  = cyc;
      e.lat = has_par ? 1520 + BIT_CLK : 1520;
      q.push_back(e);
      rx = 1'b0;
      wait_clk(BIT_CLK / 2);
      chk("busy in start bit", {31'd0, busy}, 32'd1);
      wait_clk(BIT_CLK / 2);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clk(BIT_CLK / 2);
         chk("busy in data bit", {31'd0, busy}, 32'd1);
         wait_clk(BIT_CLK / 2);
      end
      if (has_par) begin
         rx = par;
         wait_clk(BIT_CLK);
      end
      rx = stop;
      wait_clk(BIT_CLK / 4);
      chk("busy in stop bit", {31'd0, busy}, 32'd1);
      wait_clk(BIT_CLK - BIT_CLK / 4);
      if (!stop) begin
         rx = 1'b1;
         wait_clk(BIT_CLK);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      wait_clk(5);
      chk("reset outputs", {20'd0, data_out, data_ready, frame_err,
                            parity_err, busy}, 32'd0);
      rst_n = 1'b1;
      wait_clk(20);

      // 1: plain byte
      send_frame(8'h41, 1'b1, 1'b0, 1'b0);
      wait_clk(40);
      chk("s1 data_out", {24'd0, data_out}, 32'h41);
      chk("s1 idle busy", {31'd0, busy}, 32'd0);

      // 2: start glitch
      rx = 1'b0;
      wait_clk(20);
      chk("s2 busy after edge", {31'd0, busy}, 32'd1);
      wait_clk(20);
      rx = 1'b1;
      wait_clk(50);
      chk("s2 busy after glitch", {31'd0, busy}, 32'd0);
      wait_clk(200);

      // 3: framing error keeps previous byte
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      wait_clk(20);
      chk("s3 data_out held", {24'd0, data_out}, 32'h41);

      // 4: back-to-back frames
      send_frame(8'h30, 1'b1, 1'b0, 1'b0);
      send_frame(8'h39, 1'b1, 1'b0, 1'b0);
      wait_clk(40);
      chk("s4 data_out", {24'd0, data_out}, 32'h39);

      // 5: reset during bit 3 of 0xA5
      rx = 1'b0;
      wait_clk(BIT_CLK);
      rx = 1'b1;
      wait_clk(BIT_CLK);
      rx = 1'b0;
      wait_clk(BIT_CLK);
      rx = 1'b1;
      wait_clk(BIT_CLK);
      rx = 1'b0;
      wait_clk(BIT_CLK / 2);
      rst_n = 1'b0;
      exp_dout = 8'h00;
      wait_clk(3);
      chk("s5 outputs in reset", {20'd0, data_out, data_ready, frame_err,
                                  parity_err, busy}, 32'd0);
      rx = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(BIT_CLK * 10);
      chk("s5 data_out after abort", {24'd0, data_out}, 32'h00);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
      wait_clk(40);
      chk("s5 data_out", {24'd0, data_out}, 32'h7E);

`ifdef UART_RX_PARITY_EN
      // 6: parity mismatch then good parity
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      wait_clk(40);
      chk("s6 data_out held", {24'd0, data_out}, 32'h7E);
      send_frame(8'h03, 1'b1, 1'b1, 1'b0);
      wait_clk(40);
      chk("s6 data_out", {24'd0, data_out}, 32'h03);
`else
      chk("parity_err tied", {31'd0, parity_err}, 32'd0);
`endif

      for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL missing pulse: got none expected dr=%0b fe=%0b d=%0h",
                  e.dr, e.fe, e.d);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
